// File: rtl/dec_pkg.sv
// Shared decode-stage definitions: GPR geometry, writeback source indices and
// the writeback request record.
package dec_pkg;

  localparam int GPR_AW  = 5;
  localparam int GPR_NUM = 32;

  localparam int WB_SRC_ALU = 0;
  localparam int WB_SRC_FPU = 1;
  localparam int WB_SRC_LSU = 2;

  localparam int WB_XLEN = 32;

  typedef struct packed {
    logic              valid;
    logic [GPR_AW-1:0] waddr;
    logic [WB_XLEN-1:0] wd;
  } wb_req_t;

endpackage

// File: rtl/dec_gpr_wb_arb_if.sv
// Writeback request bundle between the execute/writeback units (master) and
// the GPR write-port arbiter (slave).
interface dec_gpr_wb_arb_if #(
  parameter int XLEN = 32,
  parameter int NREQ = 3
);
  // Handshake: source i transfers in a cycle where req_valid[i] & req_ready[i].
  // A source holds valid/waddr/wd stable until it sees ready; ready never
  // depends on anything the source changes after raising valid.
  logic [NREQ-1:0]      req_valid;
  logic [5*NREQ-1:0]    req_waddr;
  logic [XLEN*NREQ-1:0] req_wd;
  logic [NREQ-1:0]      req_ready;

  modport master (output req_valid, req_waddr, req_wd, input req_ready);
  modport slave  (input req_valid, req_waddr, req_wd, output req_ready);
endinterface

// File: rtl/dec_rr_arb.sv
// Round-robin grant over NREQ requesters with its pointer register; the search
// starts at the pointer and the pointer moves past whoever was granted.
module dec_rr_arb #(
  parameter int NREQ = 3,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst_l,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic            gnt_valid,
  output logic [IW-1:0]   gnt_idx,
  output logic [IW-1:0]   ptr_dbg
);

  logic [IW-1:0] ptr_q, ptr_d;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_valid && req[IW'((int'(ptr_q) + k) % NREQ)]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IW'((int'(ptr_q) + k) % NREQ);
      end
    end
    // No source may see ready while reset is asserted.
    if (!rst_l) gnt_valid = 1'b0;
    gnt   = gnt_valid ? (NREQ'(1) << gnt_idx) : '0;
    ptr_d = ptr_q;
    if (gnt_valid) ptr_d = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + IW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_l) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr_dbg = ptr_q;

endmodule

// File: rtl/dec_gpr_wb_arb.sv
// GPR write-port arbiter with pending-write scoreboard for decode hazards.
// Optional macro DEC_GPR_WB_BYPASS_EN adds write-cycle forwarding outputs.
module dec_gpr_wb_arb
  import dec_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREQ = 3
) (
  input  logic              clk,
  input  logic              rst_l,
  dec_gpr_wb_arb_if.slave   wb,
  input  logic              sb_set_valid,
  input  logic [GPR_AW-1:0] sb_set_addr,
  input  logic              flush,
  input  logic [GPR_AW-1:0] raddr0,
  input  logic [GPR_AW-1:0] raddr1,
  output logic              hazard0,
  output logic              hazard1,
  output logic              wen0,
  output logic [GPR_AW-1:0] waddr0,
  output logic [XLEN-1:0]   wd0
`ifdef DEC_GPR_WB_BYPASS_EN
  ,
  output logic              fwd_hit0,
  output logic              fwd_hit1,
  output logic [XLEN-1:0]   fwd_data0,
  output logic [XLEN-1:0]   fwd_data1
`endif
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]    gnt;
  logic               gnt_valid;
  logic [IW-1:0]      gnt_idx;
  logic [IW-1:0]      rr_ptr;
  logic [GPR_AW-1:0]  sel_waddr;
  logic [XLEN-1:0]    sel_wd;

  logic               wen0_q, wen0_d;
  logic [GPR_AW-1:0]  waddr0_q, waddr0_d;
  logic [XLEN-1:0]    wd0_q, wd0_d;
  logic [GPR_NUM-1:0] sb_q, sb_d;

  dec_rr_arb #(.NREQ(NREQ), .IW(IW)) u_arb (
    .clk       (clk),
    .rst_l     (rst_l),
    .req       (wb.req_valid),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
    .ptr_dbg   (rr_ptr)
  );

  assign wb.req_ready = gnt;
  assign sel_waddr    = wb.req_waddr[int'(gnt_idx)*GPR_AW +: GPR_AW];
  assign sel_wd       = wb.req_wd[int'(gnt_idx)*XLEN +: XLEN];

  always_comb begin
    // x0 writes are consumed but never reach the register file.
    wen0_d   = gnt_valid && (sel_waddr != '0);
    waddr0_d = gnt_valid ? sel_waddr : waddr0_q;
    wd0_d    = gnt_valid ? sel_wd    : wd0_q;

    // Clear before set so a same-cycle newer producer keeps the bit.
    sb_d = sb_q;
    if (wen0_q) sb_d[waddr0_q] = 1'b0;
    if (sb_set_valid && (sb_set_addr != '0)) sb_d[sb_set_addr] = 1'b1;
    if (flush) sb_d = '0;
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      wen0_q   <= 1'b0;
      waddr0_q <= '0;
      wd0_q    <= '0;
      sb_q     <= '0;
    end else begin
      wen0_q   <= wen0_d;
      waddr0_q <= waddr0_d;
      wd0_q    <= wd0_d;
      sb_q     <= sb_d;
    end
  end

  assign wen0   = wen0_q;
  assign waddr0 = waddr0_q;
  assign wd0    = wd0_q;

`ifdef DEC_GPR_WB_BYPASS_EN
  logic newer0, newer1;

  assign fwd_hit0  = wen0_q && (waddr0_q == raddr0) && (raddr0 != '0);
  assign fwd_hit1  = wen0_q && (waddr0_q == raddr1) && (raddr1 != '0);
  assign fwd_data0 = wd0_q;
  assign fwd_data1 = wd0_q;
  // A set landing this cycle means a younger producer still owns the register.
  assign newer0    = sb_set_valid && (sb_set_addr == raddr0);
  assign newer1    = sb_set_valid && (sb_set_addr == raddr1);
  assign hazard0   = (raddr0 != '0) && sb_q[raddr0] && !(fwd_hit0 && !newer0);
  assign hazard1   = (raddr1 != '0) && sb_q[raddr1] && !(fwd_hit1 && !newer1);
`else
  assign hazard0 = (raddr0 != '0) && sb_q[raddr0];
  assign hazard1 = (raddr1 != '0) && sb_q[raddr1];
`endif

endmodule
